// File: rtl/trng_reader_pkg.sv
// Shared types and sizing helpers for the TRNG key reader.
//   reader_state_e : reader FSM states
//   key_t          : key word at the default key width
//   cnt_width()    : occupancy counter width for a given FIFO depth
package trng_reader_pkg;

  localparam int N_BITS_KEY_DEF = 32;
  localparam int DEPTH_DEF      = 4;
  localparam int CNT_W_DEF      = $clog2(DEPTH_DEF) + 1;

  typedef logic [N_BITS_KEY_DEF-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    ACK      = 3'd2,
    DRAIN    = 3'd3,
    HOLD     = 3'd4
  } reader_state_e;

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO for key words.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : empties the FIFO; wins over push/pop in the same cycle
//   push, din : write din at the tail (must not be asserted when full)
//   pop       : drop the head word; ignored while empty
//   dout      : head word, zero while empty
//   count     : occupancy 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module key_fifo
  import trng_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_eff = push && !full;
  assign pop_eff  = pop && !empty;
  assign count    = count_reg;
  // Stale storage is hidden so the head reads as zero when nothing is held.
  assign dout     = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      assert (!full) else $error("key_fifo: push while full");
    end
  end

endmodule

// File: rtl/trng_key_reader.sv
// Consumer side of the TRNG key handshake.
//   clk, rst           : clock, synchronous active-high reset
//   enable_i           : block enable
//   clear_i            : pulse; clears fault, duplicate flag, FIFO, last key
//   trng_key_ready_i   : TRNG key valid level
//   trng_key_i         : TRNG key word
//   trng_intr_i        : TRNG total-failure interrupt
//   trng_ack_o         : one-cycle ack_read pulse to the TRNG
//   trng_enable_o      : TRNG enable, dropped while idle or the FIFO is full
//   rd_req_i           : pop request from the bus side
//   rd_data_o          : FIFO head word
//   rd_valid_o         : FIFO not empty
//   fifo_count_o       : FIFO occupancy
//   dup_err_o          : sticky repeated-key flag
//   fault_o            : sticky TRNG failure flag
//   irq_o              : fault | duplicate | rd_valid rising edge
module trng_key_reader
  import trng_reader_pkg::*;
#(
  parameter int N_BITS_KEY = 32,
  parameter int DEPTH      = 4,
  parameter int LOW_WATER  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic                        trng_key_ready_i,
  input  logic [N_BITS_KEY-1:0]       trng_key_i,
  input  logic                        trng_intr_i,
  output logic                        trng_ack_o,
  output logic                        trng_enable_o,
  input  logic                        rd_req_i,
  output logic [N_BITS_KEY-1:0]       rd_data_o,
  output logic                        rd_valid_o,
  output logic [cnt_width(DEPTH)-1:0] fifo_count_o,
  output logic                        dup_err_o,
  output logic                        fault_o,
  output logic                        irq_o
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] LOW_WATER_C = CNT_W'(LOW_WATER);

  reader_state_e           state_reg;
  logic                    ack_reg;
  logic                    en_reg;
  logic                    fault_reg;
  logic                    dup_reg;
  logic [N_BITS_KEY-1:0]   last_key_reg;
  logic                    last_valid_reg;
  logic [N_BITS_KEY-1:0]   cap_reg;
  logic                    ready_q_reg;
  logic [N_BITS_KEY-1:0]   key_q_reg;
  logic                    valid_q_reg;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    is_dup;
  logic                    push;

  assign is_dup = last_valid_reg && (cap_reg == last_key_reg);
  // The captured word is committed at the end of the ACK cycle; a clear in
  // that cycle discards it, and reset clears the FIFO before it can land.
  assign push   = (state_reg == ACK) && !is_dup && !clear_i;

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (N_BITS_KEY)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .push  (push),
    .pop   (rd_req_i),
    .din   (cap_reg),
    .dout  (rd_data_o),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_count_o  = fifo_count;
  assign rd_valid_o    = !fifo_empty;
  assign trng_ack_o    = ack_reg;
  assign trng_enable_o = en_reg;
  assign fault_o       = fault_reg;
  assign dup_err_o     = dup_reg;
  assign irq_o         = fault_reg || dup_reg || (rd_valid_o && !valid_q_reg);

  // The key inputs pass through one register stage before the FSM looks at
  // them, which puts ack two cycles after key_ready rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ack_reg        <= 1'b0;
      en_reg         <= 1'b0;
      fault_reg      <= 1'b0;
      dup_reg        <= 1'b0;
      last_key_reg   <= '0;
      last_valid_reg <= 1'b0;
      cap_reg        <= '0;
      ready_q_reg    <= 1'b0;
      key_q_reg      <= '0;
      valid_q_reg    <= 1'b0;
    end else begin
      ready_q_reg <= trng_key_ready_i;
      key_q_reg   <= trng_key_i;
      valid_q_reg <= rd_valid_o;

      if (clear_i) begin
        state_reg      <= IDLE;
        ack_reg        <= 1'b0;
        en_reg         <= 1'b0;
        fault_reg      <= 1'b0;
        dup_reg        <= 1'b0;
        last_valid_reg <= 1'b0;
      end else begin
        // The ACK-cycle word was already acknowledged, so its bookkeeping
        // completes even if the FSM is being forced to IDLE this cycle.
        if (state_reg == ACK) begin
          if (is_dup) dup_reg <= 1'b1;
          last_key_reg   <= cap_reg;
          last_valid_reg <= 1'b1;
        end

        if (trng_intr_i) begin
          fault_reg <= 1'b1;
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          en_reg    <= 1'b0;
        end else if (!enable_i) begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          en_reg    <= 1'b0;
        end else begin
          case (state_reg)
            IDLE: begin
              ack_reg <= 1'b0;
              if (!fault_reg) begin
                state_reg <= WAIT_KEY;
                en_reg    <= 1'b1;
              end
            end
            WAIT_KEY: begin
              if (ready_q_reg) begin
                if (fifo_full) begin
                  state_reg <= HOLD;
                  en_reg    <= 1'b0;
                end else begin
                  cap_reg   <= key_q_reg;
                  state_reg <= ACK;
                  ack_reg   <= 1'b1;
                end
              end
            end
            ACK: begin
              state_reg <= DRAIN;
              ack_reg   <= 1'b0;
            end
            DRAIN: begin
              // Wait for the TRNG to drop key_ready so one key is never
              // captured twice.
              if (!ready_q_reg) state_reg <= WAIT_KEY;
            end
            HOLD: begin
              if (fifo_count <= LOW_WATER_C) begin
                state_reg <= WAIT_KEY;
                en_reg    <= 1'b1;
              end
            end
            default: begin
              state_reg <= IDLE;
              ack_reg   <= 1'b0;
              en_reg    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_key_reader.sv
module tb_trng_key_reader;
  import trng_reader_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        clear_i;
  logic        trng_key_ready_i;
  key_t        trng_key_i;
  logic        trng_intr_i;
  logic        trng_ack_o;
  logic        trng_enable_o;
  logic        rd_req_i;
  key_t        rd_data_o;
  logic        rd_valid_o;
  logic [2:0]  fifo_count_o;
  logic        dup_err_o;
  logic        fault_o;
  logic        irq_o;

  trng_key_reader #(.N_BITS_KEY(32), .DEPTH(DEPTH), .LOW_WATER(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .clear_i          (clear_i),
    .trng_key_ready_i (trng_key_ready_i),
    .trng_key_i       (trng_key_i),
    .trng_intr_i      (trng_intr_i),
    .trng_ack_o       (trng_ack_o),
    .trng_enable_o    (trng_enable_o),
    .rd_req_i         (rd_req_i),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o),
    .fifo_count_o     (fifo_count_o),
    .dup_err_o        (dup_err_o),
    .fault_o          (fault_o),
    .irq_o            (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: stored keys in order, last accepted key, sticky flags.
  key_t exp_q[$];
  key_t m_last;
  bit   m_last_valid;
  bit   m_dup;
  bit   m_fault;

  int   n_checks;
  int   n_fail;
  int   ack_cnt;
  int   irq_cnt;
  int   lat;
  int   ack_base;
  int   irq_base;
  key_t k;
  key_t keys[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last_valid = 1'b0;
    m_dup        = 1'b0;
    m_fault      = 1'b0;
  endtask

  // An acknowledged key is stored unless it repeats the previous accepted one.
  task automatic model_accept(input key_t key);
    if (m_last_valid && key == m_last) begin
      m_dup = 1'b1;
      $display("key 0x%08h acked, dropped as repeat (lat %0d)", key, lat);
    end else begin
      exp_q.push_back(key);
      $display("key 0x%08h acked, stored, depth %0d (lat %0d)", key, exp_q.size(), lat);
    end
    m_last       = key;
    m_last_valid = 1'b1;
  endtask

  // Returns in the cycle where ack is high; lat counts edges since the call.
  task automatic wait_ack(output int l);
    l = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (trng_ack_o) begin
        l = c;
        break;
      end
    end
    if (l < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack, expected ack within 50 cycles");
    end
  endtask

  task automatic send_key(input key_t key, input int hold);
    trng_key_ready_i = 1'b1;
    trng_key_i       = key;
    wait_ack(lat);
    if (lat > 0) model_accept(key);
    if (hold > lat && lat > 0) tick(hold - lat);
    trng_key_ready_i = 1'b0;
  endtask

  task automatic pop_one();
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 64'(fifo_count_o), 64'(exp_q.size()));
    check({tag, "_valid"}, 64'(rd_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 64'(rd_data_o), 64'(exp_q[0]));
    check({tag, "_dup"}, 64'(dup_err_o), 64'(m_dup));
    check({tag, "_fault"}, 64'(fault_o), 64'(m_fault));
    if (m_dup || m_fault) check({tag, "_irq"}, 64'(irq_o), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_t popped;
    n_checks = 0; n_fail = 0; ack_cnt = 0; irq_cnt = 0; lat = 0;
    rst = 1'b1; enable_i = 1'b0; clear_i = 1'b0; trng_key_ready_i = 1'b0;
    trng_key_i = '0; trng_intr_i = 1'b0; rd_req_i = 1'b0;
    model_reset();

    // Monitor: every DUT pop is compared with the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (trng_ack_o) ack_cnt++;
        if (irq_o) irq_cnt++;
        if (!rst && rd_req_i && rd_valid_o) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%08h, expected empty FIFO", rd_data_o);
          end else begin
            popped = exp_q.pop_front();
            check("pop_data", 64'(rd_data_o), 64'(popped));
            $display("pop 0x%08h, %0d left", popped, exp_q.size());
          end
        end
      end
    join_none

    tick(3);
    rst = 1'b0;
    tick();
    check("rst_ack", 64'(trng_ack_o), 0);
    check("rst_en", 64'(trng_enable_o), 0);
    check("rst_irq", 64'(irq_o), 0);
    check("rst_data", 64'(rd_data_o), 0);
    check_state("rst");

    enable_i = 1'b1;
    tick();
    check("enable_on", 64'(trng_enable_o), 1);

    // Basic handshake, key_ready held for five cycles.
    ack_base = ack_cnt; irq_base = irq_cnt;
    send_key(32'hA5A5_0001, 5);
    check("basic_lat", 64'(lat), 2);
    tick(4);
    check("basic_ack_pulses", 64'(ack_cnt - ack_base), 1);
    check("basic_irq_pulses", 64'(irq_cnt - irq_base), 1);
    check_state("basic");
    pop_one();
    check_state("basic_pop");

    // Fill to DEPTH, then a fifth key stalls in HOLD.
    for (int i = 0; i < 5; i++) keys[i] = 32'hC0DE_0000 + 32'(i * 17 + 3);
    for (int i = 0; i < 4; i++) begin
      send_key(keys[i], 0);
      tick();
      check_state("fill");
    end
    ack_base = ack_cnt;
    trng_key_ready_i = 1'b1;
    trng_key_i = keys[4];
    tick(4);
    check("hold_en", 64'(trng_enable_o), 0);
    check("hold_no_ack", 64'(ack_cnt - ack_base), 0);
    check_state("hold");
    for (int i = 0; i < 3; i++) pop_one();
    tick();
    check("hold_exit_en", 64'(trng_enable_o), 1);
    wait_ack(lat);
    if (lat > 0) model_accept(keys[4]);
    trng_key_ready_i = 1'b0;
    tick();
    check_state("hold_resume");
    pop_one(); pop_one();
    check_state("hold_drained");

    // Duplicate key is acked but not stored.
    send_key(32'h1234_5678, 0); tick();
    send_key(32'h1234_5678, 0); tick();
    check_state("dup");
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    model_reset();
    check_state("dup_clear");
    tick();

    // Fault latches, blocks further keys until clear.
    trng_intr_i = 1'b1; tick(); trng_intr_i = 1'b0;
    m_fault = 1'b1;
    check("fault_en", 64'(trng_enable_o), 0);
    check_state("fault");
    ack_base = ack_cnt;
    trng_key_ready_i = 1'b1; trng_key_i = 32'hDEAD_BEEF;
    tick(6);
    trng_key_ready_i = 1'b0;
    tick(2);
    check("fault_no_ack", 64'(ack_cnt - ack_base), 0);
    check_state("fault_hold");
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    m_fault = 1'b0;
    tick();
    check("fault_resume_en", 64'(trng_enable_o), 1);
    send_key(32'h0000_0000, 0); tick();
    check_state("fault_resume");

    // Push and pop in the same cycle at count 2.
    send_key(32'hFFFF_FFFF, 0); tick();
    check_state("sim_pre");
    trng_key_ready_i = 1'b1; trng_key_i = 32'h5555_AAAA;
    wait_ack(lat);
    if (lat > 0) model_accept(32'h5555_AAAA);
    rd_req_i = 1'b1;
    trng_key_ready_i = 1'b0;
    tick();
    rd_req_i = 1'b0;
    check_state("sim_pushpop");
    pop_one(); pop_one();
    check_state("sim_drained");

    // Clear in the same cycle as the push.
    send_key(32'h0BAD_F00D, 0); tick();
    trng_key_ready_i = 1'b1; trng_key_i = 32'h7777_1111;
    wait_ack(lat);
    clear_i = 1'b1;
    trng_key_ready_i = 1'b0;
    tick();
    clear_i = 1'b0;
    model_reset();
    check_state("clear_push");
    tick(2);

    // Reset while ack is high.
    send_key(32'h3C3C_3C3C, 0); tick();
    trng_key_ready_i = 1'b1; trng_key_i = 32'h9999_0000;
    wait_ack(lat);
    rst = 1'b1;
    trng_key_ready_i = 1'b0;
    tick();
    model_reset();
    check("rstack_ack", 64'(trng_ack_o), 0);
    check("rstack_en", 64'(trng_enable_o), 0);
    check("rstack_irq", 64'(irq_o), 0);
    check_state("rstack");
    rst = 1'b0;
    tick(2);

    // Pop request on empty FIFO is ignored.
    pop_one();
    check_state("empty_pop");

    // Randomised traffic.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0 && exp_q.size() < DEPTH) begin
        case ($urandom_range(0, 5))
          0:       k = m_last_valid ? m_last : 32'h0;
          1:       k = 32'h0;
          2:       k = 32'hFFFF_FFFF;
          default: k = $urandom;
        endcase
        send_key(k, 0);
        tick();
      end else if (exp_q.size() > 0) begin
        pop_one();
      end else begin
        tick();
      end
      check_state("rand");
    end
    while (exp_q.size() > 0) pop_one();
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_key_reader.md
Name: trng_key_reader

Overview:
- Consumer side of the TRNG key handshake: samples key words on key_ready, returns a one-cycle ack_read and stores keys in a small FIFO for a software/bus reader.
- Gates the TRNG enable with FIFO occupancy, latches the TRNG failure interrupt and runs a repeated-word check on consecutive keys.
- Sits between the TRNG top and the peripheral register interface.

Parameters:
- N_BITS_KEY, 32, width of each key word.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- LOW_WATER, 1, occupancy at or below which the TRNG is re-enabled after a full stop.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable_i  in  1  block enable from the configuration register.
- clear_i  in  1  one-cycle pulse: clears the fault, duplicate flag and FIFO.
- trng_key_ready_i  in  1  TRNG key valid (level).
- trng_key_i  in  N_BITS_KEY  TRNG key word.
- trng_intr_i  in  1  TRNG total-failure interrupt.
- trng_ack_o  out  1  ack_read pulse to the TRNG.
- trng_enable_o  out  1  enable to the TRNG.
- rd_req_i  in  1  pop request from the bus side.
- rd_data_o  out  N_BITS_KEY  FIFO head word.
- rd_valid_o  out  1  FIFO not empty (rd_data_o valid).
- fifo_count_o  out  $clog2(DEPTH)+1  current occupancy.
- dup_err_o  out  1  sticky: two consecutive identical keys were seen.
- fault_o  out  1  sticky: TRNG failure latched.
- irq_o  out  1  fault_o OR dup_err_o OR (rd_valid_o rising edge, one-cycle pulse).

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; last-key register 0 and marked invalid.
- FSM states and transitions:
  - IDLE: trng_enable_o=0. Go to WAIT_KEY when enable_i=1 and fault_o=0.
  - WAIT_KEY: trng_enable_o=1. On trng_key_ready_i=1 and FIFO not full: capture trng_key_i, go to ACK. If FIFO is full, go to HOLD instead of capturing.
  - ACK: trng_ack_o=1 for exactly this one cycle. Push the captured word unless it equals the last valid key; in that case drop it and set dup_err_o. Update the last-key register. Go to DRAIN.
  - DRAIN: trng_ack_o=0. Wait for trng_key_ready_i=0, which guarantees no double capture of one key. Then go to WAIT_KEY.
  - HOLD: trng_enable_o=0. When fifo_count_o <= LOW_WATER, go to WAIT_KEY.
- From any state:
  - enable_i=0 → IDLE next cycle. FIFO contents are kept.
  - trng_intr_i=1 → set fault_o and go to IDLE. The FSM stays in IDLE until clear_i.
- Latency: trng_key_ready_i rising → trng_ack_o at +2 cycles. The word is visible on rd_data_o at +3 cycles if the FIFO was empty.
- FIFO:
  - Show-ahead: rd_data_o is the head word whenever rd_valid_o=1.
  - Pop on rd_req_i=1 and rd_valid_o=1. rd_req_i while empty is ignored.
  - Pointers wrap modulo DEPTH; count saturates neither way.
  - Simultaneous push and pop in the same cycle: count unchanged, both take effect.
  - Push is never attempted when full; the FSM guarantees it. Assert this in simulation.
- clear_i: empties the FIFO, clears fault_o and dup_err_o, invalidates the last-key register, and returns the FSM to IDLE. It has priority over a simultaneous push or pop and over trng_intr_i in the same cycle.
- A key word of all zeros or all ones is stored normally; no special case.
- Reset mid-handshake (e.g. in ACK): trng_ack_o drops in the next cycle and no partial push occurs.

Decomposition:
- Package trng_reader_pkg holds:
  - typedef enum of the FSM states (IDLE, WAIT_KEY, ACK, DRAIN, HOLD);
  - localparam for the count width;
  - typedef for the key word.
- One sub-module, key_fifo: parameterised synchronous FIFO (DEPTH, WIDTH) with push, pop, clear, count, full and empty. The reader FSM, duplicate check and irq logic stay in the top.

Test Plan:
- Basic handshake: enable_i=1, TRNG presents 0xA5A5_0001 with key_ready held 5 cycles → exactly one trng_ack_o pulse at +2, fifo_count_o=1, rd_data_o=0xA5A5_0001, irq_o pulses once.
- Fill and hold (DEPTH=4): five distinct keys, no reads → 4 stored, trng_enable_o=0 in HOLD. Pop 3 → count 1 ≤ LOW_WATER, trng_enable_o=1, fifth key accepted.
- Duplicate: keys 0x1234_5678 then 0x1234_5678 → second key acked but not stored, dup_err_o=1, count=1. clear_i → dup_err_o=0, count=0.
- Fault: trng_intr_i pulse in WAIT_KEY → fault_o=1, trng_enable_o=0 next cycle, further key_ready ignored. clear_i with enable_i=1 → WAIT_KEY resumes.
- Simultaneous: push and pop in the same cycle at count=2 → count stays 2 with correct order. clear_i coincident with a push → count=0.
- Reset in ACK: assert rst while trng_ack_o=1 → all outputs 0 next cycle, FIFO empty.
